serial_add_seq: RTL and testbench
=================================

// Module: serial_add_seq
// PURPOSE
//   Bit-serial N-bit adder sequencer built on the half-adder stage: two half-adder cells plus carry OR form one full-adder slice.
//   Loads two operands, feeds one bit pair per cycle LSB-first and shifts the sum into a result register.
//   Reports carry-out and a one-cycle done pulse. Sits between the ui_in operand pins and the uo_out result pins of the tile.
// PARAMETERS
//   WIDTH   4   operand/result width in bits; legal range 2..8
// PORTS
//   clk      in   1      single clock, rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; sampled only in IDLE or DONE
//   op_a     in   WIDTH  operand A, captured on accepted start
//   op_b     in   WIDTH  operand B, captured on accepted start
//   busy     out  1      high while in RUN
//   done     out  1      one-cycle pulse: sum/cout valid
//   sum      out  WIDTH  result, held stable until next accepted start
//   cout     out  1      final carry-out, held with sum
//   sub      in   1      only present when SERIAL_SUB_EN is defined (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, sum=0, cout=0, bit counter=0, carry=0, operand shift regs=0.
//     Reset has priority over everything and aborts RUN immediately; partial result discarded.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: start=1 -> load a_sr=op_a, b_sr=op_b, carry=0, cnt=0, sum cleared to 0; next RUN.
//     RUN:  per cycle compute on a_sr[0], b_sr[0], carry:
//           h1_s=a^b, h1_c=a&b; s=h1_s^carry, h2_c=h1_s&carry; carry<=h1_c|h2_c.
//           sum <= {s, sum[WIDTH-1:1]} (shift right, MSB-in); a_sr, b_sr shift right with 0 fill; cnt<=cnt+1.
//           When cnt==WIDTH-1 (last bit): next DONE; cout<=carry-out of that bit.
//     DONE: done=1 for exactly this cycle; busy=0. start=1 here is accepted (as IDLE) -> RUN; else -> IDLE.
//   - start while in RUN is ignored; op_a/op_b may change freely during RUN without effect.
//   - Latency: start accepted at edge T -> RUN for edges T+1..T+WIDTH -> done high in cycle after edge T+WIDTH (WIDTH+1 cycles).
//   - Back-to-back throughput: one result every WIDTH+1 cycles.
//   - sum/cout keep the last completed result through IDLE; cleared only by reset or next accepted start.
//   - Arithmetic: sum = (op_a+op_b) mod 2^WIDTH, cout = bit WIDTH of the true sum. cnt width = clog2(WIDTH), no wrap beyond WIDTH-1.
//   - busy and done never high together.
// CONFIGURATION
//   SERIAL_SUB_EN defined: port sub exists, sampled with start. sub=1 -> B bits inverted as they enter the slice and
//     initial carry=1, so sum=(op_a-op_b) mod 2^WIDTH, cout=1 means no borrow (op_a>=op_b). sub=0 -> plain add.
//   SERIAL_SUB_EN undefined: no sub port, no inverter, initial carry always 0; add only.
// TESTING (WIDTH=4)
//   1. rst=1 one cycle, then idle 3 cycles -> busy=0, done=0, sum=0, cout=0 throughout.
//   2. start, op_a=3, op_b=5 -> busy 4 cycles, done pulse in 5th cycle, sum=8, cout=0; values hold after done.
//   3. start, op_a=15, op_b=1 -> sum=0, cout=1; then op_a=15, op_b=15 -> sum=14, cout=1.
//   4. start held high across RUN with op_a/op_b changed mid-run -> single result for originally captured operands;
//      held start at DONE launches next op immediately (next done 5 cycles later).
//   5. rst=1 in 2nd RUN cycle of 6+7 -> next cycle IDLE, sum=0, cout=0, no done pulse; fresh 6+7 then gives sum=13, cout=0.
//   6. SERIAL_SUB_EN: sub=1, 5-3 -> sum=2, cout=1; sub=1, 3-5 -> sum=14, cout=0; sub=0, 3+5 -> sum=8.

Source files
------------

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder slice (two half adders + carry OR), LSB-first.
// Optional SERIAL_SUB_EN adds a 'sub' port that turns the slice into a subtractor.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             load, step;
    logic             a_bit, b_bit, carry_init;
    logic             h1_s, h1_c, h2_c, s_bit, c_next;

`ifdef SERIAL_SUB_EN
    logic sub_r;

    always_ff @(posedge clk) begin
        if (rst)       sub_r <= 1'b0;
        else if (load) sub_r <= sub;
    end

    assign b_bit      = b_sr[0] ^ sub_r;
    assign carry_init = sub;
`else
    assign b_bit      = b_sr[0];
    assign carry_init = 1'b0;
`endif

    assign a_bit  = a_sr[0];
    assign h1_s   = a_bit ^ b_bit;
    assign h1_c   = a_bit & b_bit;
    assign s_bit  = h1_s ^ carry;
    assign h2_c   = h1_s & carry;
    assign c_next = h1_c | h2_c;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result shifts in MSB-first so after WIDTH steps bit 0 sits at sum[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sr  <= op_a;
            b_sr  <= op_b;
            cnt   <= '0;
            carry <= carry_init;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (step) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            carry <= c_next;
            sum   <= {s_bit, sum[WIDTH-1:1]};
            if (cnt == LAST) cout <= c_next;
            else             cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq (WIDTH=4); define SERIAL_SUB_EN to cover the subtract path.
module tb_serial_add_seq;

    localparam int W = 4;
    localparam time P = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        time          t;
    } exp_t;

    exp_t q[$];

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_SUB_EN
        ,
        .sub   (sub)
`endif
    );

    always #(P/2) clk = ~clk;

    // Monitor: every done pulse pops one expectation and checks value and arrival time.
    always @(negedge clk) begin
        if (busy && done) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both high", busy, done);
        end
        if (done === 1'b1) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done at %0t: sum=%0d cout=%0b, required no pulse", $time, sum, cout);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (sum !== e.s || cout !== e.c || $time != e.t) begin
                    n_err++;
                    $display("FAIL result at %0t: sum=%0d cout=%0b, required sum=%0d cout=%0b at %0t",
                             $time, sum, cout, e.s, e.c, e.t);
                end
            end
        end
    end

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] s, input logic c, input time t_acc);
        exp_t e;
        e.s = s;
        e.c = c;
        e.t = t_acc + W * P + P/2;
        q.push_back(e);
    endtask

    // Drive start for one accepting edge and register the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        push_exp(es, ec, $time);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        time t0;
        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
`ifdef SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: reset state holds while idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_busy", {{W{1'b0}}, busy}, '0);
            check("reset_done", {{W{1'b0}}, done}, '0);
            check("reset_sum_cout", {cout, sum}, '0);
        end

        // 2: 3+5, busy/done profile and hold after done
        issue(4'd3, 4'd5, 4'd8, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("profile_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, (i < 4) ? 1'b1 : 1'b0});
            check("profile_done", {{W{1'b0}}, done}, {{W{1'b0}}, (i == 4) ? 1'b1 : 1'b0});
        end
        repeat (3) @(negedge clk);
        check("hold_3p5", {cout, sum}, {1'b0, 4'd8});

        // 3: carry-out cases, issued back-to-back at DONE
        issue(4'd15, 4'd1, 4'd0, 1'b1);
        repeat (W) @(posedge clk);
        issue(4'd15, 4'd15, 4'd14, 1'b1);
        drain();
        repeat (2) @(negedge clk);
        check("hold_15p15", {cout, sum}, {1'b1, 4'd14});

        // 4: start held through RUN, operands change mid-run; DONE relaunches
        @(negedge clk);
        start = 1'b1;
        op_a  = 4'd9;
        op_b  = 4'd4;
        @(posedge clk);
        t0 = $time;
        push_exp(4'd13, 1'b0, t0);
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k == 2) begin
                op_a = 4'd2;
                op_b = 4'd2;
            end
            @(posedge clk);
        end
        push_exp(4'd4, 1'b0, $time);
        #1 start = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        // 5: reset in second RUN cycle aborts; fresh run afterwards
        @(negedge clk);
        start = 1'b1;
        op_a  = 4'd6;
        op_b  = 4'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {{W{1'b0}}, busy}, '0);
        check("abort_sum_cout", {cout, sum}, '0);
        repeat (W + 2) @(negedge clk);
        check("abort_idle_sum", {cout, sum}, '0);
        issue(4'd6, 4'd7, 4'd13, 1'b0);
        drain();

`ifdef SERIAL_SUB_EN
        // 6: subtract path
        sub = 1'b1;
        issue(4'd5, 4'd3, 4'd2, 1'b1);
        drain();
        issue(4'd3, 4'd5, 4'd14, 1'b0);
        drain();
        sub = 1'b0;
        issue(4'd3, 4'd5, 4'd8, 1'b0);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
